serial_subtractor_ctrl: RTL
===========================

Name: serial_subtractor_ctrl

Overview:
- Bit-serial unsigned subtractor controller that computes diff = a_in - b_in over WIDTH clock cycles.
- Processes one bit per cycle, LSB first, through a single 1-bit full-subtractor slice built from two half-subtractor cells plus a registered borrow.
- Sits between a requester (start/done handshake) and the shared 1-bit subtract datapath, trading area for latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when ready=1.
- a_in  input  WIDTH  minuend; captured on the accepting edge.
- b_in  input  WIDTH  subtrahend; captured on the accepting edge.
- ready  output  1  high in IDLE and DONE; start is accepted when ready=1.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  result, (a_in - b_in) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when a_in < b_in.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, ready=1, busy=0, done=0, diff=0, borrow_out=0. Internal shift registers, borrow and counter are cleared.
- States:
  - IDLE: ready=1. On start=1, load a_sh<=a_in, b_sh<=b_in, bor<=0, cnt<=0, then go to SHIFT.
  - SHIFT: each cycle, d = a_sh[0]^b_sh[0]^bor and bor <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bor). Right-shift a_sh and b_sh. Shift d into the MSB of res_sh. cnt++. When cnt==WIDTH-1, go to DONE.
  - DONE: done=1 and ready=1 for exactly one cycle. diff<=res_sh (final) and borrow_out<=bor are registered on the SHIFT->DONE edge. Next state is IDLE, or SHIFT if start=1, which allows back-to-back operations with a reload identical to IDLE.
- Latency: if start is sampled on edge k, done is high during the cycle following edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- diff and borrow_out hold their values until the next operation's DONE edge. They stay stable throughout SHIFT of the next operation.
- start while busy=1 is ignored; no queueing.
- a_in and b_in are don't-care except on the accepting edge.
- Reset asserted mid-SHIFT aborts immediately to reset values. No done is produced.
- Boundary cases:
  - a=b gives diff=0, borrow_out=0.
  - a=0, b=all-ones gives diff=1, borrow_out=1.
  - cnt width is $clog2(WIDTH); terminal compare is against WIDTH-1 and never wraps.

Optional Feature:
- Macro SERSUB_SATURATE_EN.
- Defined: on the SHIFT->DONE edge, if the final bor=1, then diff<=0. borrow_out is still 1, so unsigned underflow clamps at zero.
- Undefined: diff is the modular result as above. No extra logic is present.
- Latency is identical in both builds.

Decomposition:
- Package sersub_pkg contains:
  - state enum: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - localparam for the default width.
- One sub-module, full_subtractor_bit: inputs a, b, bin; outputs d, bout.
  - Built from two half-subtractor cells plus an OR on their borrows.
  - Instantiated once in the controller datapath.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, start pulse -> done after 9 edges, diff=0x37, borrow_out=0, busy high for exactly 8 cycles.
- a=0x10, b=0x20 -> diff=0xF0, borrow_out=1. With SERSUB_SATURATE_EN defined -> diff=0x00, borrow_out=1.
- Start 0x80-0x01, then pulse start again with a=0xFF, b=0xFF at cycle 3 of SHIFT -> ignored. Result is 0x7F; no second done.
- Hold start=1 continuously with operands changing each op (0x05-0x03, then 0x03-0x05) -> done every 9 cycles, diff=0x02 then 0xFE with borrow_out=1. ready is high in the DONE cycle.
- Assert rst_n=0 during cycle 4 of SHIFT -> outputs go to reset values asynchronously. No done pulse. The next start 0xFF-0x00 gives diff=0xFF.
- Reset, then idle for 20 cycles with start=0 -> done never asserts, ready=1, diff=0.

Source files
------------

// File: rtl/sersub_pkg.sv
// Shared types and defaults for the bit-serial subtractor controller.
package sersub_pkg;

   localparam int unsigned SERSUB_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : sersub_pkg

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: two half-subtractor stages, borrows ORed together.
module full_subtractor_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_hs0_d;
   logic w_hs0_b;
   logic w_hs1_b;

   // First half-subtractor: a - b
   assign w_hs0_d = a ^ b;
   assign w_hs0_b = ~a & b;

   // Second half-subtractor: (a - b) - bin
   assign d       = w_hs0_d ^ bin;
   assign w_hs1_b = ~w_hs0_d & bin;

   assign bout    = w_hs0_b | w_hs1_b;

endmodule : full_subtractor_bit

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock through a shared slice.
// Optional build macro SERSUB_SATURATE_EN clamps an underflowing result to zero.
module serial_subtractor_ctrl
   import sersub_pkg::*;
#(
   parameter int unsigned WIDTH = SERSUB_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_ready_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-2:0] r_res_sh;
   logic             r_bor;
   logic [CNT_W-1:0] r_cnt;

   logic             w_load;
   logic             w_last;
   logic             w_d;
   logic             w_bout;
   logic [WIDTH-1:0] w_res_fin;

   assign w_load    = start & ((r_state == IDLE) | (r_state == DONE));
   assign w_last    = (r_state == SHIFT) & (r_cnt == CNT_LAST);
   assign w_res_fin = {w_d, r_res_sh};

   full_subtractor_bit u_fsub (
      .a    (r_a_sh[0]),
      .b    (r_b_sh[0]),
      .bin  (r_bor),
      .d    (w_d),
      .bout (w_bout)
   );

   // State register; handshake outputs are registered from the next-state decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         ready   <= w_ready_nxt;
         busy    <= w_busy_nxt;
         done    <= w_done_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = SHIFT;
         SHIFT:   if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = start ? SHIFT : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output decode of the upcoming state
   always_comb begin
      w_ready_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      case (w_state_nxt)
         IDLE:    w_ready_nxt = 1'b1;
         SHIFT:   w_busy_nxt  = 1'b1;
         DONE: begin
            w_ready_nxt = 1'b1;
            w_done_nxt  = 1'b1;
         end
         default: w_ready_nxt = 1'b1;
      endcase
   end

   // Serial datapath: operand shift, result assembly, borrow and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh     <= '0;
         r_b_sh     <= '0;
         r_res_sh   <= '0;
         r_bor      <= 1'b0;
         r_cnt      <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else if (w_load) begin
         r_a_sh <= a_in;
         r_b_sh <= b_in;
         r_bor  <= 1'b0;
         r_cnt  <= '0;
      end else if (r_state == SHIFT) begin
         r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
         r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
         r_res_sh <= w_res_fin[WIDTH-1:1];
         r_bor    <= w_bout;
         r_cnt    <= r_cnt + CNT_W'(1);
         if (w_last) begin
            borrow_out <= w_bout;
`ifdef SERSUB_SATURATE_EN
            diff <= w_bout ? '0 : w_res_fin;
`else
            diff <= w_res_fin;
`endif
         end
      end
   end

endmodule : serial_subtractor_ctrl
